// File: rtl/mem_bus_responder.sv
// Memory-side responder for the CPU byte bus: synchronous byte RAM, an I/O window
// with a transmit FIFO drained over valid/ready, and a status register.
module mem_bus_responder #(
  parameter int unsigned RAM_AW    = 17,
  parameter int unsigned FIFO_AW   = 3,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] bus_a,
  input  logic        bus_wr,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_overflow
);

  localparam int unsigned       DEPTH     = 1 << FIFO_AW;
  localparam logic [17:0]       TX_ADDR   = 18'h30000;
  localparam logic [17:0]       STAT_ADDR = 18'h30004;
  localparam logic [FIFO_AW:0]  CNT_FULL  = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]  CNT_ONE   = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  logic [7:0]         r_ram [0:(1 << RAM_AW)-1];
  logic [7:0]         r_fifo [0:DEPTH-1];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_overflow;
  logic [7:0]         r_rdata;

  logic [17:0]        w_addr;
  logic [RAM_AW-1:0]  w_ram_idx;
  logic               w_is_io;
  logic               w_is_ram;
  logic               w_ram_we;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_push_ok;
  logic               w_unused_hi;

  // Upper address bits are not decoded.
  assign w_unused_hi = ^bus_a[31:18];

  assign w_addr    = bus_a[17:0];
  assign w_ram_idx = bus_a[RAM_AW-1:0];
  assign w_is_io   = (w_addr[17:16] == 2'b11);
  assign w_is_ram  = !w_is_io && ({14'b0, w_addr} < (32'd1 << RAM_AW));
  assign w_ram_we  = bus_wr && w_is_ram;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_FULL);
  assign w_push    = bus_wr && (w_addr == TX_ADDR);
  assign w_pop     = !w_empty && tx_ready;
  // A push at full is still accepted when the head leaves in the same cycle.
  assign w_push_ok = w_push && (!w_full || w_pop);

  always_ff @(posedge clk_in) begin
    if (w_ram_we) begin
      r_ram[w_ram_idx] <= bus_wdata;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_rdata <= '0;
    end else if (w_is_ram) begin
      r_rdata <= r_ram[w_ram_idx];
    end else if (w_addr == STAT_ADDR) begin
      r_rdata <= {5'b0, r_overflow, w_empty, w_full};
    end else begin
      r_rdata <= '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push_ok) begin
      r_fifo[r_wr_ptr] <= bus_wdata;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus_rdata   = r_rdata;
  assign tx_data     = r_fifo[r_rd_ptr];
  assign tx_valid    = !w_empty;
  assign tx_overflow = r_overflow;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: RAM and FIFO reference models feed
// scoreboard queues that are checked as the DUT produces read data and TX bytes.
module tb_mem_bus_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] bus_a = '0;
  logic        bus_wr = 1'b0;
  logic [7:0]  bus_wdata = '0;
  logic [7:0]  bus_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tx_overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram_m [int unsigned];
  logic [7:0] txq [$];
  bit         ovf_m = 1'b0;
  logic [7:0] exp_v [$];
  bit         exp_en [$];

  mem_bus_responder #(
    .RAM_AW   (17),
    .FIFO_AW  (3),
    .INIT_FILE("")
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .bus_a      (bus_a),
    .bus_wr     (bus_wr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_overflow(tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] status_m();
    return {5'b0, ovf_m, (txq.size() == 0), (txq.size() == 8)};
  endfunction

  // One bus transaction; called at posedge+1, returns at the following posedge+1.
  task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] wd, input logic rdy);
    logic [17:0] a18;
    bit          io, ram, pop, en;
    logic [7:0]  ev;
    bus_a = a; bus_wr = wr; bus_wdata = wd; tx_ready = rdy;
    #1;
    check("tx_valid", {7'b0, tx_valid}, {7'b0, (txq.size() != 0)});
    check("tx_overflow", {7'b0, tx_overflow}, {7'b0, ovf_m});
    pop = (txq.size() != 0) && rdy;
    if (pop) check("tx_data", tx_data, txq[0]);
    a18 = a[17:0];
    io  = (a18[17:16] == 2'b11);
    ram = !io && (a18 < 18'h20000);
    en  = 1'b1;
    ev  = 8'h00;
    if (ram) begin
      if (wr || !ram_m.exists(a18)) en = 1'b0;
      else ev = ram_m[a18];
    end else if (io && a18 == 18'h30004) begin
      ev = status_m();
    end
    exp_v.push_back(ev);
    exp_en.push_back(en);
    if (pop) void'(txq.pop_front());
    if (wr && io && a18 == 18'h30000) begin
      if (txq.size() < 8) txq.push_back(wd);
      else ovf_m = 1'b1;
    end
    if (wr && ram) ram_m[a18] = wd;
    @(posedge clk_in); #1;
    ev = exp_v.pop_front();
    en = exp_en.pop_front();
    if (en) check("bus_rdata", bus_rdata, ev);
  endtask

  initial begin
    #12;
    check("reset bus_rdata", bus_rdata, 8'h00);
    check("reset tx_valid", {7'b0, tx_valid}, 8'h00);
    check("reset tx_overflow", {7'b0, tx_overflow}, 8'h00);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    // RAM write then read-back, including a pre-loaded neighbour byte.
    cyc(32'h0000_0011, 1'b1, 8'h3C, 1'b0);
    cyc(32'h0000_0000, 1'b1, 8'h5A, 1'b0);
    cyc(32'h0000_0010, 1'b1, 8'hA5, 1'b0);
    cyc(32'h0000_0010, 1'b0, 8'h00, 1'b0);
    cyc(32'h0000_0011, 1'b0, 8'h00, 1'b0);

    // Hole writes vanish and must not alias onto low RAM; upper address bits ignored.
    cyc(32'h0002_0000, 1'b1, 8'h77, 1'b0);
    cyc(32'h0002_0000, 1'b0, 8'h00, 1'b0);
    cyc(32'h0000_0000, 1'b0, 8'h00, 1'b0);
    cyc(32'hFFFC_0010, 1'b0, 8'h00, 1'b0);

    // FIFO ordering and drain.
    cyc(32'h0003_0000, 1'b1, 8'h41, 1'b0);
    cyc(32'h0003_0000, 1'b1, 8'h42, 1'b0);
    cyc(32'h0003_0000, 1'b1, 8'h43, 1'b0);
    cyc(32'h0003_0004, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cyc(32'h0003_0008, 1'b0, 8'h00, 1'b1);
    cyc(32'h0003_0004, 1'b0, 8'h00, 1'b1);
    cyc(32'h0003_0004, 1'b0, 8'h00, 1'b0);

    // Push with simultaneous pop at full is accepted without overflow.
    for (int i = 0; i < 8; i++) cyc(32'h0003_0000, 1'b1, 8'h60 + 8'(i), 1'b0);
    cyc(32'h0003_0004, 1'b0, 8'h00, 1'b0);
    cyc(32'h0003_0000, 1'b1, 8'h99, 1'b1);
    cyc(32'h0003_0004, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) cyc(32'h0003_0008, 1'b0, 8'h00, 1'b1);
    cyc(32'h0003_0004, 1'b0, 8'h00, 1'b0);

    // Full FIFO, dropped ninth push, sticky overflow.
    for (int i = 0; i < 8; i++) cyc(32'h0003_0000, 1'b1, 8'h10 + 8'(i), 1'b0);
    cyc(32'h0003_0004, 1'b0, 8'h00, 1'b0);
    cyc(32'h0003_0000, 1'b1, 8'hEE, 1'b0);
    cyc(32'h0003_0004, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) cyc(32'h0003_0008, 1'b0, 8'h00, 1'b1);
    cyc(32'h0003_0004, 1'b0, 8'h00, 1'b0);
    cyc(32'h0003_0004, 1'b0, 8'h00, 1'b0);

    // Asynchronous reset between edges while draining.
    for (int i = 0; i < 4; i++) cyc(32'h0003_0000, 1'b1, 8'hC0 + 8'(i), 1'b0);
    cyc(32'h0000_0010, 1'b0, 8'h00, 1'b1);
    #2;
    rst_in = 1'b1;
    #1;
    check("async reset tx_valid", {7'b0, tx_valid}, 8'h00);
    check("async reset bus_rdata", bus_rdata, 8'h00);
    check("async reset tx_overflow", {7'b0, tx_overflow}, 8'h00);
    tx_ready = 1'b0;
    bus_wr   = 1'b0;
    #1;
    rst_in = 1'b0;
    txq.delete();
    ovf_m = 1'b0;
    @(posedge clk_in); #1;

    // RAM survives reset; FIFO restarts empty.
    cyc(32'h0000_0010, 1'b0, 8'h00, 1'b0);
    cyc(32'h0003_0004, 1'b0, 8'h00, 1'b0);
    cyc(32'h0003_0000, 1'b1, 8'h5C, 1'b0);
    cyc(32'h0003_0008, 1'b0, 8'h00, 1'b1);
    cyc(32'h0003_0004, 1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
